split_eval_seq: RTL and testbench

Sequential, parametrised constraint evaluator for the split-constraint checking flow. The producer streams NUM_VARS operand words into an internal variable file. The block then evaluates a run-time-programmable table of NUM_CONS reduction constraints, one per cycle. It reports the AND of all enabled constraints plus a per-constraint fail mask, and sits between the variable stimulus source and the satisfiability scoreboard.

---
 rtl/split_eval_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_split_eval_seq.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_eval_seq.sv
// split_eval_seq: sequential constraint evaluator.
// The producer streams NUM_VARS operand words into a variable file. The block
// then evaluates a run-time programmable table of NUM_CONS reduction
// constraints, one slot per cycle. It reports the AND of all enabled slots, a
// per-slot fail mask and the lowest failing slot index.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   abort               synchronous soft abort; the table is kept
//   cfg_*               constraint table write port, honoured only in IDLE
//   var_valid/ready     operand beat handshake; beat k writes variable k
//   var_data            operand word
//   busy                high in LOAD or EVAL
//   result_valid/ready  result handshake; results are held in DONE
//   result_sat          AND of the evaluated enabled constraints
//   fail_mask           bit i set when enabled slot i evaluated false
//   first_fail          lowest failing slot index, 0 if none
//
// state | meaning
// IDLE  | waiting for the first beat, table writes accepted
// LOAD  | accepting beats 1 .. NUM_VARS-1
// EVAL  | evaluating one table slot per cycle
// DONE  | result_valid high, waiting for result_ready
module split_eval_seq #(
   parameter int NUM_VARS   = 10,
   parameter int VAR_W      = 64,
   parameter int NUM_CONS   = 16,
   parameter int EARLY_EXIT = 0,
   localparam int VI_W = $clog2(NUM_VARS),
   localparam int CI_W = $clog2(NUM_CONS),
   localparam int SH_W = $clog2(VAR_W)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                abort,
   input  logic                cfg_we,
   input  logic [CI_W-1:0]     cfg_addr,
   input  logic                cfg_en,
   input  logic [2:0]          cfg_op,
   input  logic [VI_W-1:0]     cfg_a,
   input  logic [VI_W-1:0]     cfg_b,
   input  logic [VAR_W-1:0]    cfg_imm,
   input  logic                var_valid,
   output logic                var_ready,
   input  logic [VAR_W-1:0]    var_data,
   output logic                busy,
   output logic                result_valid,
   input  logic                result_ready,
   output logic                result_sat,
   output logic [NUM_CONS-1:0] fail_mask,
   output logic [CI_W-1:0]     first_fail
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EVAL, ST_DONE} state_t;

   localparam logic [VI_W-1:0] LAST_VAR = VI_W'(NUM_VARS - 1);
   localparam logic [CI_W-1:0] LAST_CON = CI_W'(NUM_CONS - 1);

   state_t                state_q, state_d;
   logic                  rdy_en_q;
   logic [VI_W-1:0]       cnt_q, cnt_d;
   logic [CI_W-1:0]       idx_q, idx_d;
   logic [VAR_W-1:0]      vars_q [NUM_VARS];
   logic [VAR_W-1:0]      vars_d [NUM_VARS];
   logic [NUM_CONS-1:0]   tbl_en_q, tbl_en_d;
   logic [2:0]            tbl_op_q  [NUM_CONS];
   logic [2:0]            tbl_op_d  [NUM_CONS];
   logic [VI_W-1:0]       tbl_a_q   [NUM_CONS];
   logic [VI_W-1:0]       tbl_a_d   [NUM_CONS];
   logic [VI_W-1:0]       tbl_b_q   [NUM_CONS];
   logic [VI_W-1:0]       tbl_b_d   [NUM_CONS];
   logic [VAR_W-1:0]      tbl_imm_q [NUM_CONS];
   logic [VAR_W-1:0]      tbl_imm_d [NUM_CONS];
   logic [NUM_CONS-1:0]   fail_mask_q, fail_mask_d;
   logic [CI_W-1:0]       first_fail_q, first_fail_d;
   logic                  result_sat_q, result_sat_d;
   logic                  result_valid_q, result_valid_d;

   logic                  cur_en, cur_true, cur_fail;
   logic [2:0]            cur_op;
   logic [VI_W-1:0]       cur_a, cur_b;
   logic [VAR_W-1:0]      cur_imm, op_a, op_b;
   logic                  beat_acc;

   // rdy_en_q keeps var_ready low until the first clock after reset release
   assign var_ready    = rdy_en_q && (state_q == ST_IDLE || state_q == ST_LOAD);
   assign busy         = (state_q == ST_LOAD) || (state_q == ST_EVAL);
   assign result_valid = result_valid_q;
   assign result_sat   = result_sat_q;
   assign fail_mask    = fail_mask_q;
   assign first_fail   = first_fail_q;
   assign beat_acc     = var_valid && var_ready;

   always_comb begin : eval_slot
      cur_en   = 1'b0;
      cur_op   = '0;
      cur_a    = '0;
      cur_b    = '0;
      cur_imm  = '0;
      op_a     = '0;
      op_b     = '0;
      cur_true = 1'b0;
      for (int i = 0; i < NUM_CONS; i++) begin
         if (idx_q == CI_W'(i)) begin
            cur_en  = tbl_en_q[i];
            cur_op  = tbl_op_q[i];
            cur_a   = tbl_a_q[i];
            cur_b   = tbl_b_q[i];
            cur_imm = tbl_imm_q[i];
         end
      end
      // indices past NUM_VARS match no entry and read as zero
      for (int i = 0; i < NUM_VARS; i++) begin
         if (cur_a == VI_W'(i)) op_a = vars_q[i];
         if (cur_b == VI_W'(i)) op_b = vars_q[i];
      end
      case (cur_op)
         3'd0:    cur_true = |(op_a & op_b);
         3'd1:    cur_true = |(op_a ^ op_b);
         3'd2:    cur_true = |(op_a ^ cur_imm);
         3'd3:    cur_true = (op_a == '0) || (op_b != '0);
         3'd4:    cur_true = |((op_a << cur_imm[SH_W-1:0]) & op_b);
         3'd5:    cur_true = |(op_a | op_b);
         3'd6:    cur_true = 1'b1;
         default: cur_true = 1'b0;
      endcase
      cur_fail = cur_en && !cur_true;
   end

   always_comb begin : next_state
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      vars_d         = vars_q;
      tbl_en_d       = tbl_en_q;
      tbl_op_d       = tbl_op_q;
      tbl_a_d        = tbl_a_q;
      tbl_b_d        = tbl_b_q;
      tbl_imm_d      = tbl_imm_q;
      fail_mask_d    = fail_mask_q;
      first_fail_d   = first_fail_q;
      result_sat_d   = result_sat_q;
      result_valid_d = result_valid_q;

      if (state_q == ST_IDLE && cfg_we) begin
         for (int i = 0; i < NUM_CONS; i++) begin
            if (cfg_addr == CI_W'(i)) begin
               tbl_en_d[i]  = cfg_en;
               tbl_op_d[i]  = cfg_op;
               tbl_a_d[i]   = cfg_a;
               tbl_b_d[i]   = cfg_b;
               tbl_imm_d[i] = cfg_imm;
            end
         end
      end

      if (abort) begin
         // any beat presented together with abort is dropped
         state_d        = ST_IDLE;
         cnt_d          = '0;
         idx_d          = '0;
         result_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_LOAD: begin
               if (beat_acc) begin
                  for (int i = 0; i < NUM_VARS; i++) begin
                     if (cnt_q == VI_W'(i)) vars_d[i] = var_data;
                  end
                  if (cnt_q == LAST_VAR) begin
                     state_d      = ST_EVAL;
                     cnt_d        = '0;
                     idx_d        = '0;
                     fail_mask_d  = '0;
                     first_fail_d = '0;
                     result_sat_d = 1'b0;
                  end else begin
                     state_d = ST_LOAD;
                     cnt_d   = cnt_q + 1'b1;
                  end
               end
            end
            ST_EVAL: begin
               if (cur_fail) begin
                  for (int i = 0; i < NUM_CONS; i++) begin
                     if (idx_q == CI_W'(i)) fail_mask_d[i] = 1'b1;
                  end
                  // slots run in ascending order, so the first failure is the lowest
                  if (fail_mask_q == '0) first_fail_d = idx_q;
               end
               if (idx_q == LAST_CON || (EARLY_EXIT != 0 && cur_fail)) begin
                  state_d        = ST_DONE;
                  idx_d          = '0;
                  result_valid_d = 1'b1;
                  result_sat_d   = (fail_mask_d == '0);
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  state_d        = ST_IDLE;
                  result_valid_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rdy_en_q       <= 1'b0;
         cnt_q          <= '0;
         idx_q          <= '0;
         vars_q         <= '{default: '0};
         tbl_en_q       <= '0;
         tbl_op_q       <= '{default: '0};
         tbl_a_q        <= '{default: '0};
         tbl_b_q        <= '{default: '0};
         tbl_imm_q      <= '{default: '0};
         fail_mask_q    <= '0;
         first_fail_q   <= '0;
         result_sat_q   <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rdy_en_q       <= 1'b1;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         vars_q         <= vars_d;
         tbl_en_q       <= tbl_en_d;
         tbl_op_q       <= tbl_op_d;
         tbl_a_q        <= tbl_a_d;
         tbl_b_q        <= tbl_b_d;
         tbl_imm_q      <= tbl_imm_d;
         fail_mask_q    <= fail_mask_d;
         first_fail_q   <= first_fail_d;
         result_sat_q   <= result_sat_d;
         result_valid_q <= result_valid_d;
      end
   end

endmodule

// File: tb/tb_split_eval_seq.sv
// Bench for split_eval_seq. Two instances share all inputs: dut runs with
// EARLY_EXIT=0 and dut_e with EARLY_EXIT=1. Expected results come from a
// behavioural model that applies the constraint rules to the bench's own copy
// of the table and operands.
module tb_split_eval_seq;

   logic        clk = 1'b0;
   logic        rst_n, abort, cfg_we, cfg_en, var_valid, result_ready;
   logic [3:0]  cfg_addr, cfg_a, cfg_b;
   logic [2:0]  cfg_op;
   logic [63:0] cfg_imm, var_data;

   logic        var_ready, busy, result_valid, result_sat;
   logic [15:0] fail_mask;
   logic [3:0]  first_fail;
   logic        var_ready_e, busy_e, result_valid_e, result_sat_e;
   logic [15:0] fail_mask_e;
   logic [3:0]  first_fail_e;

   int checks = 0;
   int errors = 0;

   logic        m_en  [16];
   logic [2:0]  m_op  [16];
   logic [3:0]  m_a   [16];
   logic [3:0]  m_b   [16];
   logic [63:0] m_imm [16];
   logic [63:0] m_var [10];

   int          lat_m, lat_e;
   logic        sat_m, sat_e;
   logic [15:0] mask_m, mask_e;
   logic [3:0]  ff_m, ff_e;

   int          x_lat, xe_lat;
   logic        x_sat, xe_sat;
   logic [15:0] x_mask, xe_mask;
   logic [3:0]  x_ff, xe_ff;

   always #5 clk = ~clk;

   split_eval_seq #(.NUM_VARS(10), .VAR_W(64), .NUM_CONS(16), .EARLY_EXIT(0)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_en(cfg_en), .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_imm(cfg_imm),
      .var_valid(var_valid), .var_ready(var_ready), .var_data(var_data), .busy(busy),
      .result_valid(result_valid), .result_ready(result_ready), .result_sat(result_sat),
      .fail_mask(fail_mask), .first_fail(first_fail));

   split_eval_seq #(.NUM_VARS(10), .VAR_W(64), .NUM_CONS(16), .EARLY_EXIT(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .abort(abort), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_en(cfg_en), .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_imm(cfg_imm),
      .var_valid(var_valid), .var_ready(var_ready_e), .var_data(var_data), .busy(busy_e),
      .result_valid(result_valid_e), .result_ready(result_ready), .result_sat(result_sat_e),
      .fail_mask(fail_mask_e), .first_fail(first_fail_e));

   // Constraint rules applied directly; lat counts clock edges after the last beat.
   function automatic void ref_eval(input bit ee, output logic sat, output logic [15:0] mask,
                                    output logic [3:0] ff, output int lat);
      logic [63:0] a, b;
      bit t, stop;
      mask = '0; ff = '0; lat = 16; stop = 0;
      for (int c = 0; c < 16; c++) begin
         if (stop || !m_en[c]) continue;
         a = (m_a[c] < 4'd10) ? m_var[m_a[c]] : 64'd0;
         b = (m_b[c] < 4'd10) ? m_var[m_b[c]] : 64'd0;
         case (m_op[c])
            3'd0: t = (a & b) != 0;
            3'd1: t = a != b;
            3'd2: t = a != m_imm[c];
            3'd3: t = (a == 0) || (b != 0);
            3'd4: t = ((a << m_imm[c][5:0]) & b) != 0;
            3'd5: t = (a | b) != 0;
            3'd6: t = 1;
            default: t = 0;
         endcase
         if (!t) begin
            if (mask == '0) ff = c[3:0];
            mask[c] = 1'b1;
            if (ee) begin lat = c + 1; stop = 1; end
         end
      end
      sat = (mask == '0);
   endfunction

   function automatic logic [63:0] rval();
      case ($urandom_range(0, 3))
         0: rval = 64'd0;
         1: rval = 64'd1 << $urandom_range(0, 63);
         2: rval = {$urandom, $urandom};
         default: rval = 64'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic cfg_write(input int addr, input bit en, input int op, input int a, input int b,
                            input logic [63:0] imm, input bit upd);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = addr[3:0]; cfg_en = en; cfg_op = op[2:0];
      cfg_a = a[3:0]; cfg_b = b[3:0]; cfg_imm = imm;
      @(negedge clk);
      cfg_we = 1'b0;
      if (upd) begin
         m_en[addr] = en; m_op[addr] = op[2:0]; m_a[addr] = a[3:0]; m_b[addr] = b[3:0];
         m_imm[addr] = imm;
      end
   endtask

   task automatic disable_all();
      for (int i = 0; i < 16; i++) cfg_write(i, 0, 0, 0, 0, 64'd0, 1);
   endtask

   task automatic stream_vars();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         var_valid = 1'b1; var_data = m_var[k];
         @(posedge clk);
      end
      @(negedge clk);
      var_valid = 1'b0;
   endtask

   // Observe both instances until each has raised result_valid (bounded).
   task automatic wait_result();
      lat_m = -1; lat_e = -1;
      for (int c = 1; c <= 60 && (lat_m < 0 || lat_e < 0); c++) begin
         @(posedge clk); #1;
         if (lat_m < 0 && result_valid) begin
            lat_m = c; sat_m = result_sat; mask_m = fail_mask; ff_m = first_fail;
         end
         if (lat_e < 0 && result_valid_e) begin
            lat_e = c; sat_e = result_sat_e; mask_e = fail_mask_e; ff_e = first_fail_e;
         end
      end
   endtask

   task automatic release_result();
      @(negedge clk); result_ready = 1'b1;
      @(negedge clk); result_ready = 1'b0;
   endtask

   task automatic rand_vars();
      for (int k = 0; k < 10; k++) m_var[k] = rval();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (var_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b busy=%b rv=%b want 0 0 0", var_ready, busy, result_valid);
      end
      checks++;
      if ({result_sat, fail_mask, first_fail} !== 21'd0) begin
         errors++;
         $display("FAIL reset_result got sat=%b mask=%h ff=%0d want 0", result_sat, fail_mask, first_fail);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (var_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b busy=%b want 1 0", var_ready, busy);
      end
   endtask

   task automatic test_xori_zero();
      cfg_write(0, 1, 2, 0, 0, 64'd0, 1);
      rand_vars(); m_var[0] = 64'd0;
      stream_vars(); wait_result();
      checks++;
      if (lat_m !== 16) begin errors++; $display("FAIL xori0_lat got %0d want 16", lat_m); end
      checks++;
      if ({sat_m, mask_m, ff_m} !== {1'b0, 16'h0001, 4'd0}) begin
         errors++; $display("FAIL xori0_res got sat=%b mask=%h ff=%0d want 0 0001 0", sat_m, mask_m, ff_m);
      end
      checks++;
      if (lat_e !== 1 || mask_e !== 16'h0001) begin
         errors++; $display("FAIL xori0_ee got lat=%0d mask=%h want 1 0001", lat_e, mask_e);
      end
      release_result();
   endtask

   task automatic test_xori_nonzero();
      rand_vars(); m_var[0] = 64'he755720a5;
      stream_vars(); wait_result();
      checks++;
      if ({sat_m, mask_m} !== {1'b1, 16'h0000} || lat_m !== 16) begin
         errors++; $display("FAIL xori1_res got sat=%b mask=%h lat=%0d want 1 0000 16", sat_m, mask_m, lat_m);
      end
      release_result();
   endtask

   task automatic test_shl();
      cfg_write(3, 1, 4, 7, 8, 64'd50, 1);
      rand_vars(); m_var[0] = 64'h55; m_var[7] = 64'd1; m_var[8] = 64'd1 << 50;
      stream_vars(); wait_result();
      checks++;
      if ({sat_m, mask_m} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL shl_pass got sat=%b mask=%h want 1 0000", sat_m, mask_m);
      end
      release_result();
      m_var[8] = 64'd1 << 49;
      stream_vars(); wait_result();
      checks++;
      if ({sat_m, mask_m, ff_m} !== {1'b0, 16'h0008, 4'd3}) begin
         errors++; $display("FAIL shl_fail got sat=%b mask=%h ff=%0d want 0 0008 3", sat_m, mask_m, ff_m);
      end
      checks++;
      if (lat_e !== 4 || mask_e !== 16'h0008) begin
         errors++; $display("FAIL shl_ee got lat=%0d mask=%h want 4 0008", lat_e, mask_e);
      end
      release_result();
   endtask

   task automatic test_early_exit();
      disable_all();
      cfg_write(2, 1, 7, 0, 0, 64'd0, 1);
      cfg_write(5, 1, 7, 0, 0, 64'd0, 1);
      rand_vars();
      stream_vars(); wait_result();
      checks++;
      if (lat_e !== 3 || {sat_e, mask_e, ff_e} !== {1'b0, 16'h0004, 4'd2}) begin
         errors++;
         $display("FAIL ee_res got lat=%0d sat=%b mask=%h ff=%0d want 3 0 0004 2", lat_e, sat_e, mask_e, ff_e);
      end
      checks++;
      if (lat_m !== 16 || {sat_m, mask_m, ff_m} !== {1'b0, 16'h0024, 4'd2}) begin
         errors++;
         $display("FAIL noee_res got lat=%0d sat=%b mask=%h ff=%0d want 16 0 0024 2", lat_m, sat_m, mask_m, ff_m);
      end
      release_result();
   endtask

   task automatic test_cfg_in_eval();
      disable_all();
      cfg_write(1, 1, 6, 0, 0, 64'd0, 1);
      rand_vars();
      stream_vars();
      cfg_write(0, 1, 7, 0, 0, 64'd0, 0);
      wait_result();
      checks++;
      if ({sat_m, mask_m} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL cfg_eval_run got sat=%b mask=%h want 1 0000", sat_m, mask_m);
      end
      release_result();
      stream_vars(); wait_result();
      checks++;
      if ({sat_m, mask_m} !== {1'b1, 16'h0000} || lat_m !== 16) begin
         errors++; $display("FAIL cfg_eval_rerun got sat=%b mask=%h lat=%0d want 1 0000 16", sat_m, mask_m, lat_m);
      end
      release_result();
   endtask

   task automatic test_abort_load();
      cfg_write(0, 1, 2, 0, 0, 64'd0, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); var_valid = 1'b1; var_data = 64'hdead_0000 + 64'(k) + 1;
      end
      @(negedge clk); var_valid = 1'b0; abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || var_ready !== 1'b1) begin
         errors++; $display("FAIL abort_load_idle got busy=%b rdy=%b want 0 1", busy, var_ready);
      end
      rand_vars(); m_var[0] = 64'd0;
      stream_vars(); wait_result();
      ref_eval(0, x_sat, x_mask, x_ff, x_lat);
      checks++;
      if (lat_m !== x_lat || {sat_m, mask_m, ff_m} !== {x_sat, x_mask, x_ff}) begin
         errors++;
         $display("FAIL abort_load_res got lat=%0d sat=%b mask=%h ff=%0d want %0d %b %h %0d",
                  lat_m, sat_m, mask_m, ff_m, x_lat, x_sat, x_mask, x_ff);
      end
      release_result();
   endtask

   task automatic test_abort_last_beat();
      rand_vars(); m_var[0] = 64'd0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); var_valid = 1'b1; var_data = m_var[k]; abort = (k == 9);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++; $display("FAIL abort_last_beat got busy=%b rv=%b want 0 0", busy, result_valid);
      end
      @(negedge clk); var_valid = 1'b0; abort = 1'b0;
      stream_vars(); wait_result();
      checks++;
      if (lat_m !== 16 || {sat_m, mask_m, ff_m} !== {1'b0, 16'h0001, 4'd0}) begin
         errors++;
         $display("FAIL abort_last_rerun got lat=%0d sat=%b mask=%h ff=%0d want 16 0 0001 0", lat_m, sat_m, mask_m, ff_m);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      rand_vars(); m_var[0] = 64'd0;
      stream_vars(); wait_result();
      @(negedge clk); result_ready = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || var_ready !== 1'b1 || fail_mask !== mask_m) begin
         errors++;
         $display("FAIL abort_done got rv=%b busy=%b rdy=%b mask=%h want 0 0 1 %h", result_valid, busy, var_ready, fail_mask, mask_m);
      end
      @(negedge clk); abort = 1'b0;
      rand_vars(); m_var[0] = 64'h1234;
      stream_vars(); wait_result();
      ref_eval(0, x_sat, x_mask, x_ff, x_lat);
      checks++;
      if (lat_m !== x_lat || {sat_m, mask_m, ff_m} !== {x_sat, x_mask, x_ff}) begin
         errors++;
         $display("FAIL b2b_res got lat=%0d sat=%b mask=%h want %0d %b %h", lat_m, sat_m, mask_m, x_lat, x_sat, x_mask);
      end
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b0 || var_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_idle got rv=%b rdy=%b want 0 1", result_valid, var_ready);
      end
      @(negedge clk); var_valid = 1'b1; var_data = 64'd7;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
      @(negedge clk); var_valid = 1'b0; abort = 1'b1; result_ready = 1'b0;
      @(negedge clk); abort = 1'b0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         for (int c = 0; c < 16; c++) begin
            cfg_write(c, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 11),
                      $urandom_range(0, 11), ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 63)) : rval(), 1);
         end
         rand_vars();
         stream_vars(); wait_result();
         ref_eval(0, x_sat, x_mask, x_ff, x_lat);
         ref_eval(1, xe_sat, xe_mask, xe_ff, xe_lat);
         checks++;
         if (lat_m !== x_lat || {sat_m, mask_m, ff_m} !== {x_sat, x_mask, x_ff}) begin
            errors++;
            $display("FAIL rand_main it=%0d got lat=%0d sat=%b mask=%h ff=%0d want %0d %b %h %0d",
                     it, lat_m, sat_m, mask_m, ff_m, x_lat, x_sat, x_mask, x_ff);
         end
         checks++;
         if (lat_e !== xe_lat || {sat_e, mask_e, ff_e} !== {xe_sat, xe_mask, xe_ff}) begin
            errors++;
            $display("FAIL rand_ee it=%0d got lat=%0d sat=%b mask=%h ff=%0d want %0d %b %h %0d",
                     it, lat_e, sat_e, mask_e, ff_e, xe_lat, xe_sat, xe_mask, xe_ff);
         end
         release_result();
      end
   endtask

   task automatic test_hold_done();
      rand_vars();
      stream_vars(); wait_result();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         checks++;
         if (result_valid !== 1'b1 || var_ready !== 1'b0 || fail_mask !== mask_m ||
             result_sat !== sat_m || first_fail !== ff_m) begin
            errors++;
            $display("FAIL hold_done c=%0d got rv=%b rdy=%b mask=%h sat=%b ff=%0d want 1 0 %h %b %0d",
                     c, result_valid, var_ready, fail_mask, result_sat, first_fail, mask_m, sat_m, ff_m);
         end
      end
      release_result();
   endtask

   task automatic test_reset_mid_eval();
      for (int c = 0; c < 16; c++) cfg_write(c, 1, 7, 0, 0, 64'd0, 1);
      rand_vars();
      stream_vars();
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({var_ready, busy, result_valid, result_sat, fail_mask, first_fail} !== 24'd0 ||
          {var_ready_e, busy_e, result_valid_e, result_sat_e, fail_mask_e, first_fail_e} !== 24'd0) begin
         errors++;
         $display("FAIL rst_mid got rdy=%b busy=%b rv=%b sat=%b mask=%h ff=%0d ee_mask=%h want all 0",
                  var_ready, busy, result_valid, result_sat, fail_mask, first_fail, fail_mask_e);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 16; c++) begin
         m_en[c] = 1'b0; m_op[c] = 3'd0; m_a[c] = '0; m_b[c] = '0; m_imm[c] = '0;
      end
      @(posedge clk); #1;
      checks++;
      if (var_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got %b want 1", var_ready); end
      rand_vars();
      stream_vars(); wait_result();
      checks++;
      if (lat_m !== 16 || {sat_m, mask_m, ff_m} !== {1'b1, 16'h0000, 4'd0} || lat_e !== 16 || sat_e !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_rerun got lat=%0d sat=%b mask=%h ee_lat=%0d ee_sat=%b want 16 1 0000 16 1",
                  lat_m, sat_m, mask_m, lat_e, sat_e);
      end
      release_result();
   endtask

   initial begin
      abort = 0; cfg_we = 0; cfg_addr = 0; cfg_en = 0; cfg_op = 0; cfg_a = 0; cfg_b = 0;
      cfg_imm = 0; var_valid = 0; var_data = 0; result_ready = 0; rst_n = 0;
      for (int c = 0; c < 16; c++) begin
         m_en[c] = 1'b0; m_op[c] = 3'd0; m_a[c] = '0; m_b[c] = '0; m_imm[c] = '0;
      end
      for (int k = 0; k < 10; k++) m_var[k] = '0;
      test_reset();
      test_xori_zero();
      test_xori_nonzero();
      test_shl();
      test_early_exit();
      test_cfg_in_eval();
      test_abort_load();
      test_abort_last_beat();
      test_back_to_back();
      test_hold_done();
      test_random();
      test_reset_mid_eval();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
